mem_word_transfer_unit: RTL
===========================

Name: mem_word_transfer_unit

Overview:
- Parametrised byte-serial load/store engine between the datapath and the byte-wide memory.
- Store: splits a DATA_W-bit word into bytes. Load: assembles a word from successive memory bytes.
- Replaces per-byte micro-steps with one Start-triggered transfer of 1..DATA_W/8 bytes.
- Adds selectable endianness, sign extension, address wrap and abort.

Parameters:
DATA_W, 32, word width in bits; power of two, multiple of 8, >= 16; BYTES = DATA_W/8
ADDR_W, 16, memory address width; address arithmetic is modulo 2^ADDR_W
BIG_ENDIAN, 0, 0: byte k at bits [8k+7:8k]; 1: byte k at byte lane (Size-k)
SZ_W, clog2(BYTES), width of Size port (derived, not overridden)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled on Clock when state is IDLE or DONE
Op  input  1  0 = load, 1 = store; latched with Start
Size  input  SZ_W  byte count minus 1; latched with Start
Signed  input  1  load only: 1 = sign-extend from the top transferred byte; latched with Start
Abort  input  1  synchronous cancel during XFER/WAIT
BaseAddr  input  ADDR_W  first byte address; latched with Start
StoreData  input  DATA_W  store word; latched with Start
LoadData  output  DATA_W  assembled load word; held between loads
Busy  output  1  high in XFER and WAIT
Done  output  1  one-cycle pulse in DONE
Mem_Address  output  ADDR_W  byte address
Mem_En  output  1  memory access enable, active-high
Mem_WR  output  1  1 = write, 0 = read; only meaningful with Mem_En
Mem_DataOut  output  8  write byte
Mem_DataIn  input  8  read byte; valid the cycle after the read is issued

Behaviour:
- States: IDLE, XFER, WAIT, DONE.
- Reset (async, any state) -> IDLE. Every output is 0 while Reset is high. The internal byte counter and shift register are cleared.
- IDLE, Start=1: latch Op/Size/Signed/BaseAddr/StoreData, set k=0, go to XFER. Start=0: stay in IDLE.
- XFER: lasts N = Size+1 cycles, k = 0..N-1.
  - Mem_En=1, Mem_WR=Op, Mem_Address = BaseAddr+k (mod 2^ADDR_W; wraps FFFF->0000 at ADDR_W=16).
  - Store: Mem_DataOut = latched byte lane L(k). L(k)=k if BIG_ENDIAN=0, else Size-k.
  - Load: Mem_DataIn captured into lane L(k-1) at the end of cycle k (k>=1). Mem_DataOut=0.
  - After cycle N-1 -> WAIT.
- WAIT (1 cycle):
  - Mem_En=0.
  - Load: last byte captured into lane L(N-1). Store: idle slot, keeps latency uniform.
  - -> DONE.
- DONE (1 cycle): Done=1, Busy=0.
  - On entry, for loads only, LoadData updates to the assembled word. Lanes above Size are 0, or copies of bit 8*(Size+1)-1 if Signed.
  - Stores leave LoadData unchanged.
  - Start=1 in DONE: accepted as in IDLE -> XFER (back-to-back). Otherwise -> IDLE.
- Latency: Start sampled at edge 0; XFER occupies cycles 1..N; WAIT is cycle N+1; Done=1 in cycle N+2.
- Start while Busy: ignored, no latch.
- Abort=1 in XFER or WAIT: next edge -> IDLE. No Done, LoadData unchanged, Mem_En=0 from that edge. Bytes already written stay written. Abort is ignored in IDLE/DONE.
- Abort and Start both high in IDLE: Start wins.
- Size=BYTES-1 with Signed=1: no extension bits remain, word passes unchanged.
- Outside XFER: Mem_En=0, Mem_WR=0, Mem_Address=0.

Test Plan:
- Reset mid-store: assert Reset in XFER cycle 2 -> Mem_En=0 at once, state IDLE, no Done, LoadData=0.
- Store, LE: Op=1, Size=3, BaseAddr=0x0010, StoreData=0xA1B2C3D4 -> writes 10:D4, 11:C3, 12:B2, 13:A1. Done in cycle 6, Busy high in cycles 1-5.
- Load, BE, signed: BIG_ENDIAN=1, memory 20:0x80, 21:0x01, Op=0, Size=1, Signed=1 -> LoadData=0xFFFF8001 with Done. Signed=0 -> 0x00008001.
- Wrap: Op=1, Size=2, BaseAddr=0xFFFF, StoreData=0x00112233 -> writes FFFF:33, 0000:22, 0001:11.
- Abort and back-to-back:
  - Abort in load XFER cycle 1 -> IDLE next edge, no Done, previous LoadData held.
  - Then two loads with Start held high through DONE -> second XFER starts the cycle after the first Done. Both results are correct.
- Start while Busy: pulse Start with new BaseAddr=0x0050 during XFER -> ignored; addresses continue from the original BaseAddr.

Source files
------------

// File: rtl/mem_word_transfer_unit.sv
// Byte-serial load/store engine between a DATA_W-bit datapath and a byte-wide memory.
// A single Start moves 1..BYTES bytes. Endianness, sign extension, address wrap and abort are supported.
module mem_word_transfer_unit #(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 16,
    parameter bit  BIG_ENDIAN = 1'b0,
    localparam int BYTES      = DATA_W / 8,
    localparam int SZ_W       = $clog2(BYTES)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [SZ_W-1:0]   i_size,
    input  logic              i_signed,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [DATA_W-1:0] i_store_data,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [7:0]        o_mem_data_out,
    input  logic [7:0]        i_mem_data_in
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_op;
    logic                r_signed;
    logic [SZ_W-1:0]     r_size;
    logic [SZ_W-1:0]     r_k;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_store_data;
    logic [DATA_W-1:0]   r_capture;
    logic [DATA_W-1:0]   r_load_data;

    logic                w_accept;
    logic                w_cap_en;
    logic [SZ_W-1:0]     w_cap_idx;
    logic [SZ_W-1:0]     w_cap_lane;
    logic [SZ_W-1:0]     w_out_lane;
    logic [7:0]          w_store_byte;
    logic                w_ext;
    logic [DATA_W-1:0]   w_assembled;
    logic [DATA_W-1:0]   w_final;

    // A new request is only taken when the engine is not busy.
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);

    // A read byte arrives one cycle after its address, so the capture trails k by one;
    // the last byte lands during WAIT.
    assign w_cap_en   = !r_op && ((r_state == S_XFER && r_k != '0) || r_state == S_WAIT);
    assign w_cap_idx  = (r_state == S_WAIT) ? r_size : (r_k - SZ_W'(1));
    assign w_cap_lane = BIG_ENDIAN ? (r_size - w_cap_idx) : w_cap_idx;
    assign w_out_lane = BIG_ENDIAN ? (r_size - r_k) : r_k;

    assign w_store_byte = r_store_data[{w_out_lane, 3'b000} +: 8];

    // The sign comes from the top transferred byte, i.e. bit 8*(Size+1)-1 of the assembled word.
    assign w_ext = r_signed & w_assembled[{r_size, 3'b111}];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign w_assembled[8*gi +: 8] = (w_cap_en && w_cap_lane == SZ_W'(gi)) ?
                                            i_mem_data_in : r_capture[8*gi +: 8];
            assign w_final[8*gi +: 8]     = (SZ_W'(gi) <= r_size) ?
                                            w_assembled[8*gi +: 8] : {8{w_ext}};
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: abort wins over progress inside a transfer; Start is honoured in IDLE and DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_accept ? S_XFER : S_IDLE;
            S_XFER:  w_state_next = i_abort ? S_IDLE : ((r_k == r_size) ? S_WAIT : S_XFER);
            S_WAIT:  w_state_next = i_abort ? S_IDLE : S_DONE;
            S_DONE:  w_state_next = w_accept ? S_XFER : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from state so they all drop as soon as reset forces IDLE.
    always_comb begin
        o_busy         = (r_state == S_XFER) || (r_state == S_WAIT);
        o_done         = (r_state == S_DONE);
        o_mem_en       = (r_state == S_XFER);
        o_mem_wr       = (r_state == S_XFER) && r_op;
        o_mem_address  = (r_state == S_XFER) ? (r_base + ADDR_W'(r_k)) : '0;
        o_mem_data_out = ((r_state == S_XFER) && r_op) ? w_store_byte : 8'h00;
    end

    // Request latch, byte counter and load capture register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_op         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= '0;
            r_k          <= '0;
            r_base       <= '0;
            r_store_data <= '0;
            r_capture    <= '0;
        end else if (w_accept) begin
            r_op         <= i_op;
            r_signed     <= i_signed;
            r_size       <= i_size;
            r_k          <= '0;
            r_base       <= i_base_addr;
            r_store_data <= i_store_data;
            r_capture    <= '0;
        end else begin
            if (r_state == S_XFER && r_k != r_size) begin
                r_k <= r_k + SZ_W'(1);
            end
            if (w_cap_en) begin
                r_capture <= w_assembled;
            end
        end
    end

    // The visible load word changes only when a load completes unaborted.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_load_data <= '0;
        end else if (r_state == S_WAIT && !i_abort && !r_op) begin
            r_load_data <= w_final;
        end
    end

    assign o_load_data = r_load_data;

endmodule
